// File: rtl/softplus_grad_piped.sv
// Softplus backward pass: grad_out = grad_in * sigmoid(x), with a shift-only PLAN sigmoid.
// Two-stage valid/ready pipeline with full backpressure; Q4.11 sign-magnitude data.
module softplus_grad_piped #(
    parameter int unsigned FRAC_BITS = 11,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] x_in_i,
    input  logic [DATA_W-1:0] grad_in_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] grad_out_o,
    output logic [DATA_W-1:0] sig_out_o
);

    localparam logic [15:0] One = 16'h0800;

    logic        v1_q, v2_q;
    logic        en1, en2;
    logic [15:0] grad1_q, sig1_q;
    logic [15:0] grad_out_q, sig_out_q;
    logic [15:0] sig_d, grad_d;
    logic [15:0] sig_pos;
    logic [14:0] mag_a;
    logic [29:0] prod;
    logic [14:0] prod_mag;
    logic        unused_prod;

    assign en2        = !v2_q || out_ready_i;
    assign en1        = !v1_q || en2;
    assign in_ready_o = en1;

    // Piecewise-linear sigmoid on |x|, mirrored about 0.5 for negative x.
    always_comb begin
        mag_a   = x_in_i[14:0];
        sig_pos = One;
        if (mag_a < 15'h0800) begin
            sig_pos = {3'b000, mag_a[14:2]} + 16'h0400;
        end else if (mag_a < 15'h1300) begin
            sig_pos = {4'b0000, mag_a[14:3]} + 16'h0500;
        end else if (mag_a < 15'h2800) begin
            sig_pos = {6'b000000, mag_a[14:5]} + 16'h06C0;
        end
        sig_d = x_in_i[15] ? (One - sig_pos) : sig_pos;
    end

    // Sigmoid <= 1.0, so the truncated product never exceeds |grad_in| and needs no saturation.
    assign prod        = {15'b0, grad1_q[14:0]} * {15'b0, sig1_q[14:0]};
    assign prod_mag    = prod[FRAC_BITS +: 15];
    assign unused_prod = ^{prod[29:FRAC_BITS+15], prod[FRAC_BITS-1:0]};

    always_comb begin
        grad_d = {grad1_q[15] && (prod_mag != 15'd0), prod_mag};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            grad1_q <= 16'h0000;
            sig1_q  <= 16'h0000;
        end else if (en1) begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                grad1_q <= grad_in_i;
                sig1_q  <= sig_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q       <= 1'b0;
            grad_out_q <= 16'h0000;
            sig_out_q  <= 16'h0000;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                grad_out_q <= grad_d;
                sig_out_q  <= sig1_q;
            end
        end
    end

    assign out_valid_o = v2_q;
    assign grad_out_o  = grad_out_q;
    assign sig_out_o   = sig_out_q;

endmodule
